wb_elastic_latch: RTL

- Parametrised successor of the single-entry cache-to-writeback latch.
- Replaces the stall-driven register with a DEPTH-entry elastic FIFO and valid/ready handshakes on both sides.
- Carries {data, reg_write_enable, write_addr} from the cache stage to the writeback stage.
- kill_i flushes all in-flight writes.

---
 rtl/wb_elastic_latch.sv | 111 +++++++++++
 1 files changed

// File: rtl/wb_elastic_latch.sv
// wb_elastic_latch: DEPTH-entry elastic FIFO carrying {data, reg_write_enable, write_addr} from cache to writeback.
// Optional WB_ELASTIC_BYPASS_EN adds a zero-latency combinational path from c_* to w_* while the FIFO is empty.
module wb_elastic_latch #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     kill_i,
    input  logic                     c_valid_i,
    output logic                     c_ready_o,
    input  logic [DATA_W-1:0]        c_data_i,
    input  logic                     c_reg_write_enable_i,
    input  logic [ADDR_W-1:0]        c_write_addr_i,
    output logic                     w_valid_o,
    input  logic                     w_ready_i,
    output logic [DATA_W-1:0]        w_data_o,
    output logic                     w_reg_write_enable_o,
    output logic [ADDR_W-1:0]        w_write_addr_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = DATA_W + 1 + ADDR_W;
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     count;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic               head_valid;
    logic [ENTRY_W-1:0] in_entry;
    logic [ENTRY_W-1:0] head_entry;
    logic [ENTRY_W-1:0] out_entry;

    assign full       = (count == FULL_COUNT);
    assign empty      = (count == '0);
    assign in_entry   = {c_data_i, c_reg_write_enable_i, c_write_addr_i};
    assign head_entry = mem[rd_ptr];
    // kill masks the head so a flushed write is never seen as consumed
    assign head_valid = !empty && !kill_i;
    assign pop        = head_valid && w_ready_i;

`ifdef WB_ELASTIC_BYPASS_EN
    logic bypass_active;
    logic bypass_take;

    assign bypass_active = empty && c_valid_i && !kill_i;
    assign bypass_take   = bypass_active && w_ready_i;
    // an entry consumed straight through the bypass is never written
    assign push          = c_valid_i && !full && !bypass_take;
`else
    assign push          = c_valid_i && !full;
`endif

    always_comb begin
        w_valid_o = head_valid;
        out_entry = empty ? '0 : head_entry;
`ifdef WB_ELASTIC_BYPASS_EN
        if (bypass_active) begin
            w_valid_o = 1'b1;
            out_entry = in_entry;
        end
`endif
    end

    assign {w_data_o, w_reg_write_enable_o, w_write_addr_o} = out_entry;

    assign count_o   = count;
    assign full_o    = full;
    assign empty_o   = empty;
    assign c_ready_o = !full;

    // Storage is deliberately not reset; empty masking hides stale contents.
    always_ff @(posedge clk_i) begin
        if (push && !kill_i) begin
            mem[wr_ptr] <= in_entry;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (kill_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
